// File: rtl/guess_grader.sv
// guess_grader: sequential Znarly/Zood scorer for one Guess against the
// loaded master pattern. The grader does one exact-match pass over the slots,
// then one wrong-slot pass over the guess slots, and then presents the result
// for a single DONE cycle. It also keeps the per-game round count and the
// win and rounds-exhausted flags that the game FSM reads.
module guess_grader #(
    parameter int SLOTS      = 4,
    parameter int SHAPE_W    = 3,
    parameter int MAX_ROUNDS = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       startGame,
    input  logic                       gradeIt,
    input  logic [SLOTS*SHAPE_W-1:0]   masterPattern,
    input  logic [SLOTS*SHAPE_W-1:0]   Guess,
    output logic [3:0]                 Znarly,
    output logic [3:0]                 Zood,
    output logic                       doneGrading,
    output logic                       busy,
    output logic [3:0]                 RoundNumber,
    output logic                       gameWon,
    output logic                       roundsExhausted
);

    localparam int PAT_W = SLOTS * SHAPE_W;
    localparam int ACC_W = $clog2(SLOTS + 1);
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SLOTS - 1);
    localparam logic [ACC_W-1:0] ALL_EXACT = ACC_W'(SLOTS);
    localparam logic [3:0]       MAX_RN    = 4'(MAX_ROUNDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXACT = 2'd1,
        ZOOD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idxNext;
    logic             accept;

    // Captured operands; pure data, only loaded on accept.
    logic [PAT_W-1:0] masterReg;
    logic [PAT_W-1:0] guessReg;

    // Slots already consumed by an exact or wrong-slot match.
    logic [SLOTS-1:0] mUsed;
    logic [SLOTS-1:0] gUsed;

    logic [ACC_W-1:0] znarlyAcc;
    logic [ACC_W-1:0] zoodAcc;
    logic [ACC_W-1:0] zoodAccNext;

    logic [SHAPE_W-1:0] masterSlot;
    logic [SHAPE_W-1:0] guessSlot;
    logic               exactHit;
    logic               zoodHit;
    logic [SLOTS-1:0]   zoodPick;
    logic [3:0]         roundNext;

    // Extract shape k from a packed pattern; slot 0 is the least significant.
    function automatic logic [SHAPE_W-1:0] slotOf(input logic [PAT_W-1:0] pat,
                                                  input int k);
        return pat[SHAPE_W*k +: SHAPE_W];
    endfunction

    // Comparisons for the slot addressed by idx in the current pass.
    always_comb begin
        masterSlot = slotOf(masterReg, int'(idx));
        guessSlot  = slotOf(guessReg, int'(idx));
        exactHit   = (masterSlot == guessSlot);
    end

    // Wrong-slot search: lowest unused master slot holding this guess shape.
    always_comb begin
        zoodHit  = 1'b0;
        zoodPick = '0;
        if (!gUsed[idx]) begin
            for (int j = 0; j < SLOTS; j++) begin
                if (!zoodHit && !mUsed[j] && (slotOf(masterReg, j) == guessSlot)) begin
                    zoodHit     = 1'b1;
                    zoodPick[j] = 1'b1;
                end
            end
        end
    end

    // Final-cycle values: Zood including the last guess slot, next round count.
    always_comb begin
        zoodAccNext = zoodAcc + ACC_W'(zoodHit);
        roundNext   = (RoundNumber >= MAX_RN) ? MAX_RN : RoundNumber + 4'd1;
    end

    // State register and pass index.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
        end
    end

    // Next-state logic, accept decision and handshake outputs.
    always_comb begin
        stateNext   = state;
        idxNext     = idx;
        accept      = 1'b0;
        busy        = (state != IDLE);
        doneGrading = (state == DONE);
        case (state)
            IDLE: begin
                // startGame clears the flags this same edge, so it re-enables grading.
                if (gradeIt && (startGame || (!gameWon && !roundsExhausted))) begin
                    accept    = 1'b1;
                    stateNext = EXACT;
                    idxNext   = '0;
                end
            end
            EXACT: begin
                if (idx == LAST_IDX) begin
                    stateNext = ZOOD;
                    idxNext   = '0;
                end else begin
                    idxNext = idx + IDX_W'(1);
                end
            end
            ZOOD: begin
                if (idx == LAST_IDX) begin
                    stateNext = DONE;
                    idxNext   = '0;
                end else begin
                    idxNext = idx + IDX_W'(1);
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
                idxNext   = '0;
            end
        endcase
    end

    // Operand capture on accept.
    always_ff @(posedge clock) begin
        if (accept) begin
            masterReg <= masterPattern;
            guessReg  <= Guess;
        end
    end

    // Match flags and accumulators for the two scoring passes.
    always_ff @(posedge clock) begin
        if (reset) begin
            mUsed     <= '0;
            gUsed     <= '0;
            znarlyAcc <= '0;
            zoodAcc   <= '0;
        end else if (accept) begin
            mUsed     <= '0;
            gUsed     <= '0;
            znarlyAcc <= '0;
            zoodAcc   <= '0;
        end else if (state == EXACT) begin
            if (exactHit) begin
                mUsed[idx] <= 1'b1;
                gUsed[idx] <= 1'b1;
                znarlyAcc  <= znarlyAcc + ACC_W'(1);
            end
        end else if (state == ZOOD) begin
            if (zoodHit) begin
                mUsed   <= mUsed | zoodPick;
                zoodAcc <= zoodAccNext;
            end
        end
    end

    // Result outputs and game bookkeeping, updated on entry to DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            Znarly          <= '0;
            Zood            <= '0;
            RoundNumber     <= '0;
            gameWon         <= 1'b0;
            roundsExhausted <= 1'b0;
        end else if ((state == IDLE) && startGame) begin
            RoundNumber     <= '0;
            gameWon         <= 1'b0;
            roundsExhausted <= 1'b0;
        end else if ((state == ZOOD) && (idx == LAST_IDX)) begin
            Znarly      <= 4'(znarlyAcc);
            Zood        <= 4'(zoodAccNext);
            RoundNumber <= roundNext;
            if (znarlyAcc == ALL_EXACT) begin
                gameWon <= 1'b1;
            end else if (roundNext == MAX_RN) begin
                roundsExhausted <= 1'b1;
            end
        end
    end

endmodule
